// File: rtl/fc_layer_sequencer.sv
// fc_layer_sequencer: runs the FC stages of the classifier head one after
// another from a single start. Each stage's level-sensitive enable is held
// through its RUN, then every enable is dropped for CLEAR_CYCLES so the stage
// returns to idle before the next one starts. It also steers the ping-pong
// activation banks so that each layer reads the previous layer's output.
// Optional feature: define FC_SEQ_WATCHDOG_EN to add the RUN watchdog and the
// sticky ERR state. Without it, err is tied low and RUN waits indefinitely.
module fc_layer_sequencer #(
   parameter int unsigned      NUM_LAYERS   = 3,
   parameter int unsigned      CLEAR_CYCLES = 2,
   parameter int unsigned      CNT_W        = 16,
   parameter logic [CNT_W-1:0] TIMEOUT      = 16'd20000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic [NUM_LAYERS-1:0] fc_done,
   output logic [NUM_LAYERS-1:0] fc_en,
   output logic [1:0]            layer_idx,
   output logic                  src_is_input,
   output logic                  buf_wr_sel,
   output logic                  buf_rd_sel,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [CNT_W-1:0]      last_cycles
);

   localparam int unsigned CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

   if (NUM_LAYERS < 2 || NUM_LAYERS > 4) begin : g_bad_layers
      $error("fc_layer_sequencer: NUM_LAYERS must be in 2..4");
   end
   if (CLEAR_CYCLES < 1) begin : g_bad_clear
      $error("fc_layer_sequencer: CLEAR_CYCLES must be at least 1");
   end
   if (TIMEOUT == '0) begin : g_bad_timeout
      $error("fc_layer_sequencer: TIMEOUT must be nonzero");
   end

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RUN    = 3'd1,
      CLEAR  = 3'd2,
      FINISH = 3'd3
`ifdef FC_SEQ_WATCHDOG_EN
      ,ERR   = 3'd4
`endif
   } state_t;

   state_t                  state_q, state_d;
   logic [1:0]              layer_q, layer_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_inc;
   logic [CLR_W-1:0]        clr_q, clr_d;
   logic [CNT_W-1:0]        last_q, last_d;
   logic [NUM_LAYERS-1:0]   en_q, en_d;
   logic                    busy_q, busy_d;
   logic                    src_q, src_d;
   logic                    rd_q, rd_d;
   logic                    done_q, done_d;
   logic                    err_q, err_d;

   // Next-state, counters and registered-output decode from the next state
   always_comb begin
      state_d = state_q;
      layer_d = layer_q;
      cnt_d   = cnt_q;
      clr_d   = clr_q;
      last_d  = last_q;
      cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               layer_d = '0;
               cnt_d   = '0;
            end
         end
         RUN: begin
            cnt_d = cnt_inc;
            if (fc_done[layer_q]) begin
               last_d  = cnt_inc;
               clr_d   = '0;
               state_d = CLEAR;
            end
`ifdef FC_SEQ_WATCHDOG_EN
            else if (cnt_inc == TIMEOUT) begin
               state_d = ERR;
            end
`endif
         end
         CLEAR: begin
            if (clr_q == CLR_W'(CLEAR_CYCLES - 1)) begin
               if (layer_q == 2'(NUM_LAYERS - 1)) begin
                  state_d = FINISH;
               end else begin
                  layer_d = layer_q + 2'd1;
                  cnt_d   = '0;
                  state_d = RUN;
               end
            end else begin
               clr_d = clr_q + 1'b1;
            end
         end
         FINISH: state_d = IDLE;
`ifdef FC_SEQ_WATCHDOG_EN
         ERR: begin
            if (start) begin
               state_d = RUN;
               layer_d = '0;
               cnt_d   = '0;
            end
         end
`endif
         default: state_d = IDLE;
      endcase

      // abort overrides any transition above but leaves last_cycles alone
      if (abort) begin
         state_d = IDLE;
         layer_d = '0;
         last_d  = last_q;
      end

      en_d = '0;
      if (state_d == RUN) en_d[layer_d] = 1'b1;
      busy_d = (state_d == RUN) || (state_d == CLEAR);
      src_d  = (state_d == RUN) && (layer_d == 2'd0);
      rd_d   = busy_d && !layer_d[0];
      done_d = (state_d == FINISH);
`ifdef FC_SEQ_WATCHDOG_EN
      err_d  = (state_d == ERR);
`else
      err_d  = 1'b0;
`endif
   end

   // State, counters and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         layer_q <= '0;
         cnt_q   <= '0;
         clr_q   <= '0;
         last_q  <= '0;
         en_q    <= '0;
         busy_q  <= 1'b0;
         src_q   <= 1'b0;
         rd_q    <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         layer_q <= layer_d;
         cnt_q   <= cnt_d;
         clr_q   <= clr_d;
         last_q  <= last_d;
         en_q    <= en_d;
         busy_q  <= busy_d;
         src_q   <= src_d;
         rd_q    <= rd_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign fc_en        = en_q;
   assign layer_idx    = layer_q;
   assign src_is_input = src_q;
   assign buf_wr_sel   = layer_q[0];
   assign buf_rd_sel   = rd_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign last_cycles  = last_q;
`ifdef FC_SEQ_WATCHDOG_EN
   assign err          = err_q;
`else
   assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Testbench for fc_layer_sequencer (3 layers, CLEAR_CYCLES=2). Expected
// outputs come from a per-cycle timeline built from the stage run lengths;
// stub stages raise fc_done after their configured number of enabled cycles.
module tb_fc_layer_sequencer;

   localparam int CLR = 2;
`ifdef FC_SEQ_WATCHDOG_EN
   localparam logic [15:0] TB_TIMEOUT = 16'd100;
`else
   localparam logic [15:0] TB_TIMEOUT = 16'd20000;
`endif

   logic        clk = 1'b0;
   logic        rst, start, abort;
   logic [2:0]  fc_done, fc_en;
   logic [1:0]  layer_idx;
   logic        src_is_input, buf_wr_sel, buf_rd_sel, busy, done, err;
   logic [15:0] last_cycles;

   int          errors = 0;
   int          checks = 0;
   logic [15:0] prev_last = 16'd0;

   typedef struct {
      logic [2:0]  en;
      logic        busy;
      logic        done;
      logic [1:0]  layer;
      logic [15:0] last;
      logic        src;
      logic        src_chk;
   } exp_t;

   fc_layer_sequencer #(
      .NUM_LAYERS  (3),
      .CLEAR_CYCLES(CLR),
      .CNT_W       (16),
      .TIMEOUT     (TB_TIMEOUT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .abort       (abort),
      .fc_done     (fc_done),
      .fc_en       (fc_en),
      .layer_idx   (layer_idx),
      .src_is_input(src_is_input),
      .buf_wr_sel  (buf_wr_sel),
      .buf_rd_sel  (buf_rd_sel),
      .busy        (busy),
      .done        (done),
      .err         (err),
      .last_cycles (last_cycles)
   );

   always #5 clk = ~clk;

   // Runs one start-to-idle sequence and checks every cycle against the
   // timeline. cut_c>0 injects abort (or rst) in that cycle, after which the
   // expected outputs are idle.
   task automatic run_seq(input int l0, input int l1, input int l2,
                          input int cut_c, input logic cut_is_rst,
                          input logic [2:0] cut_done, input int xstart_c,
                          input int spur_c, input logic [2:0] spur_mask,
                          output int done_at);
      exp_t        sched[$];
      exp_t        e;
      int          lens[3];
      int          cnt[3];
      logic [2:0]  stub;
      logic [15:0] lastv;
      logic [15:0] cut_last;
      int          ncyc;

      lens  = '{l0, l1, l2};
      lastv = prev_last;
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < lens[k]; i++) begin
            e.en = 3'(1 << k); e.busy = 1'b1; e.done = 1'b0; e.layer = 2'(k);
            e.last = lastv; e.src = (k == 0); e.src_chk = 1'b1;
            sched.push_back(e);
         end
         lastv = 16'(lens[k]);
         for (int i = 0; i < CLR; i++) begin
            e.en = 3'b000; e.busy = 1'b1; e.done = 1'b0; e.layer = 2'(k);
            e.last = lastv; e.src = 1'b0; e.src_chk = 1'b0;
            sched.push_back(e);
         end
      end
      e.en = 3'b000; e.busy = 1'b0; e.done = 1'b1; e.layer = 2'd2;
      e.last = lastv; e.src = 1'b0; e.src_chk = 1'b1;
      sched.push_back(e);
      e.done = 1'b0;
      sched.push_back(e);

      cut_last = 16'd0;
      if (cut_c > 0 && !cut_is_rst) cut_last = sched[cut_c-1].last;

      cnt = '{0, 0, 0};
      done_at = 0;
      ncyc = sched.size() + 2;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c <= ncyc; c++) begin
         if (cut_c > 0 && c > cut_c) begin
            e.en = 3'b000; e.busy = 1'b0; e.done = 1'b0; e.layer = 2'd0;
            e.last = cut_last; e.src = 1'b0; e.src_chk = 1'b1;
         end else if (c <= sched.size()) begin
            e = sched[c-1];
         end else begin
            e = sched[sched.size()-1];
         end

         checks++;
         if (fc_en !== e.en) begin
            errors++; $display("FAIL fc_en cycle %0d: got %b want %b", c, fc_en, e.en);
         end
         checks++;
         if (busy !== e.busy) begin
            errors++; $display("FAIL busy cycle %0d: got %b want %b", c, busy, e.busy);
         end
         checks++;
         if (done !== e.done) begin
            errors++; $display("FAIL done cycle %0d: got %b want %b", c, done, e.done);
         end
         checks++;
         if (layer_idx !== e.layer) begin
            errors++; $display("FAIL layer_idx cycle %0d: got %0d want %0d", c, layer_idx, e.layer);
         end
         checks++;
         if (last_cycles !== e.last) begin
            errors++; $display("FAIL last_cycles cycle %0d: got %0d want %0d", c, last_cycles, e.last);
         end
         checks++;
         if (err !== 1'b0) begin
            errors++; $display("FAIL err cycle %0d: got %b want 0", c, err);
         end
         checks++;
         if (buf_wr_sel !== e.layer[0]) begin
            errors++; $display("FAIL buf_wr_sel cycle %0d: got %b want %b", c, buf_wr_sel, e.layer[0]);
         end
         if (e.busy) begin
            checks++;
            if (buf_rd_sel !== !e.layer[0]) begin
               errors++; $display("FAIL buf_rd_sel cycle %0d: got %b want %b", c, buf_rd_sel, !e.layer[0]);
            end
         end
         if (e.src_chk) begin
            checks++;
            if (src_is_input !== e.src) begin
               errors++; $display("FAIL src_is_input cycle %0d: got %b want %b", c, src_is_input, e.src);
            end
         end
         if (done === 1'b1 && done_at == 0) done_at = c;

         stub = 3'b000;
         for (int k = 0; k < 3; k++) begin
            if (fc_en[k] === 1'b1) begin
               cnt[k]++;
               if (cnt[k] == lens[k]) stub[k] = 1'b1;
            end else begin
               cnt[k] = 0;
            end
         end
         fc_done = stub | ((c == spur_c) ? spur_mask : 3'b000)
                        | ((c == cut_c) ? cut_done : 3'b000);
         abort = (c == cut_c) && !cut_is_rst;
         rst   = (c == cut_c) && cut_is_rst;
         start = (c == xstart_c);
         @(posedge clk); #1;
      end
      fc_done = 3'b000; abort = 1'b0; rst = 1'b0; start = 1'b0;
      prev_last = (cut_c > 0) ? cut_last : 16'(l2);
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; abort = 1'b0; fc_done = 3'b000;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({fc_en, layer_idx, src_is_input, buf_wr_sel, buf_rd_sel, busy, done, err} !== 10'd0) begin
         errors++;
         $display("FAIL reset outputs: got en=%b idx=%0d src=%b wr=%b rd=%b busy=%b done=%b err=%b want all 0",
                  fc_en, layer_idx, src_is_input, buf_wr_sel, buf_rd_sel, busy, done, err);
      end
      checks++;
      if (last_cycles !== 16'd0) begin
         errors++; $display("FAIL reset last_cycles: got %0d want 0", last_cycles);
      end
      rst = 1'b0;
      prev_last = 16'd0;
   endtask

   task automatic test_sequence;
      int d;
      run_seq(50, 40, 30, 0, 1'b0, 3'b000, 0, 0, 3'b000, d);
      checks++;
      if (d != 127) begin
         errors++; $display("FAIL seq done latency: got %0d want 127", d);
      end
      checks++;
      if (last_cycles !== 16'd30) begin
         errors++; $display("FAIL seq last_cycles: got %0d want 30", last_cycles);
      end
   endtask

   task automatic test_ignored_inputs;
      int d;
      run_seq(50, 40, 30, 0, 1'b0, 3'b000, 60, 10, 3'b110, d);
      checks++;
      if (d != 127) begin
         errors++; $display("FAIL ignored done latency: got %0d want 127", d);
      end
   endtask

   task automatic test_random;
      int d, a, b, c;
      for (int r = 0; r < 3; r++) begin
         a = int'($urandom_range(1, 40));
         b = int'($urandom_range(1, 40));
         c = int'($urandom_range(1, 40));
         run_seq(a, b, c, 0, 1'b0, 3'b000, 0, 0, 3'b000, d);
         checks++;
         if (d != a + b + c + 3 * CLR + 1) begin
            errors++; $display("FAIL random latency %0d/%0d/%0d: got %0d want %0d", a, b, c, d, a + b + c + 3 * CLR + 1);
         end
      end
   endtask

   task automatic test_abort;
      int d;
      run_seq(50, 40, 30, 60, 1'b0, 3'b010, 0, 0, 3'b000, d);
      checks++;
      if (d != 0) begin
         errors++; $display("FAIL abort done pulse: got cycle %0d want none", d);
      end
      start = 1'b1; abort = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      checks++;
      if (busy !== 1'b0 || fc_en !== 3'b000 || layer_idx !== 2'd0) begin
         errors++; $display("FAIL start+abort: got busy=%b en=%b idx=%0d want 0/000/0", busy, fc_en, layer_idx);
      end
      repeat (3) @(posedge clk);
      #1;
      run_seq(5, 6, 7, 0, 1'b0, 3'b000, 0, 0, 3'b000, d);
      checks++;
      if (d != 5 + 6 + 7 + 3 * CLR + 1) begin
         errors++; $display("FAIL restart latency: got %0d want %0d", d, 5 + 6 + 7 + 3 * CLR + 1);
      end
   endtask

   task automatic test_watchdog;
`ifdef FC_SEQ_WATCHDOG_EN
      fc_done = 3'b000;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c <= 100; c++) begin
         checks++;
         if (fc_en !== 3'b001 || err !== 1'b0) begin
            errors++; $display("FAIL wd run cycle %0d: got en=%b err=%b want 001/0", c, fc_en, err);
         end
         @(posedge clk); #1;
      end
      checks++;
      if (fc_en !== 3'b000 || err !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL wd fire: got en=%b err=%b busy=%b want 000/1/0", fc_en, err, busy);
      end
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (err !== 1'b1) begin
         errors++; $display("FAIL wd sticky: got err=%b want 1", err);
      end
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if (err !== 1'b0 || fc_en !== 3'b001) begin
         errors++; $display("FAIL wd restart: got err=%b en=%b want 0/001", err, fc_en);
      end
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      checks++;
      if (fc_en !== 3'b000 || busy !== 1'b0) begin
         errors++; $display("FAIL wd abort: got en=%b busy=%b want 000/0", fc_en, busy);
      end
`endif
   endtask

   task automatic test_rst_mid;
      int d;
      run_seq(50, 40, 30, 104, 1'b1, 3'b000, 0, 0, 3'b000, d);
      checks++;
      if (d != 0) begin
         errors++; $display("FAIL rst-mid done pulse: got cycle %0d want none", d);
      end
   endtask

   initial begin
      test_reset();
      test_sequence();
      test_ignored_inputs();
      test_random();
      test_abort();
      test_watchdog();
      test_rst_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
